// File: rtl/road_sensor_avg_pkg.sv
// ---------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the road sensor averager slice: road direction
// codes, selection FSM states, default sizing constants and a small helper
// that turns log2 window depth into a slot count.
// No ports (package).
// ---------------------------------------------------------------------------
package sensor_pkg;

    // Default sizing, reused as parameter defaults by the modules below
    localparam int DATA_W_DEF   = 8;
    localparam int SIZE_DEF     = 6;
    localparam int INIT_VAL_DEF = 20;
    localparam int ROAD_W_DEF   = 2;

    // Direction codes as driven by the signal controller on next_road
    typedef enum logic [ROAD_W_DEF-1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } road_e;

    // Selection FSM: IDLE waits for a grant, GRANTED blocks further
    // captures until the grant moves to another road
    typedef enum logic {
        SEL_IDLE    = 1'b0,
        SEL_GRANTED = 1'b1
    } sel_e;

    // Number of window slots for a given log2 depth
    function automatic int windowLen(input int size);
        return 1 << size;
    endfunction

endpackage : sensor_pkg

// File: rtl/road_sensor_avg_if.sv
// ---------------------------------------------------------------------------
// road_sensor_avg_if
// Bundles the controller/sensor-facing signals of one road averager.
//   next_road   : road currently granted by the controller
//   data_in     : vehicle count for this road
//   avg         : registered window average
//   avg_valid   : one-cycle pulse when avg has just updated
//   window_full : high once a full window of real samples is captured
//   congested   : congestion flag (constant 0 unless CONGESTION_FLAG_EN)
// Modports: master = controller/sensor side, slave = averager side.
// ---------------------------------------------------------------------------
interface road_sensor_avg_if
    import sensor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROAD_W = ROAD_W_DEF
) ();

    logic [ROAD_W-1:0] next_road;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] avg;
    logic              avg_valid;
    logic              window_full;
    logic              congested;

    modport master (
        output next_road,
        output data_in,
        input  avg,
        input  avg_valid,
        input  window_full,
        input  congested
    );

    modport slave (
        input  next_road,
        input  data_in,
        output avg,
        output avg_valid,
        output window_full,
        output congested
    );

endinterface : road_sensor_avg_if

// File: rtl/road_sensor_avg_ram.sv
// ---------------------------------------------------------------------------
// sensor_window_ram
// Circular buffer of the last 2**SIZE samples plus their running sum.
// A write replaces the oldest slot (the one the write pointer addresses)
// and adjusts the sum by (new - oldest), so the sum never needs a full
// re-add of the window.
// Ports:
//   clk          : system clock
//   reset        : synchronous active-high; all slots reload INIT_VAL
//   i_wr_en      : write the sample this cycle
//   i_wr_data    : sample to write
//   o_sum_next   : sum the window would hold after writing i_wr_data now
// ---------------------------------------------------------------------------
module sensor_window_ram
    import sensor_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SIZE     = SIZE_DEF,
    parameter int INIT_VAL = INIT_VAL_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [DATA_W-1:0]    i_wr_data,
    output logic [DATA_W+SIZE-1:0] o_sum_next
);

    localparam int LEN   = windowLen(SIZE);
    localparam int SUM_W = DATA_W + SIZE;

    logic [DATA_W-1:0] r_vehicles [LEN];
    logic [SIZE-1:0]   r_wr_ptr;
    logic [SUM_W-1:0]  r_sum;
    logic [SUM_W-1:0]  w_sum_next;

    // Sum after replacing the oldest slot; modular arithmetic is safe
    // because the true result is always a non-negative window total
    assign w_sum_next = r_sum + SUM_W'(i_wr_data) - SUM_W'(r_vehicles[r_wr_ptr]);
    assign o_sum_next = w_sum_next;

    // Window storage, pointer and running sum; the pointer wraps
    // naturally at LEN because it is exactly SIZE bits wide
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LEN; i++) begin
                r_vehicles[i] <= DATA_W'(INIT_VAL);
            end
            r_sum    <= SUM_W'(LEN * INIT_VAL);
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_vehicles[r_wr_ptr] <= i_wr_data;
            r_sum                <= w_sum_next;
            r_wr_ptr             <= r_wr_ptr + SIZE'(1);
        end
    end

endmodule : sensor_window_ram

// File: rtl/road_sensor_avg.sv
// ---------------------------------------------------------------------------
// road_sensor_avg
// Per-road vehicle-count averager. Captures one count per green grant to
// ROAD_ID, keeps a 2**SIZE sample window and publishes a registered average
// with a one-cycle valid strobe.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high
//   bus    : road_sensor_avg_if.slave (next_road, data_in in;
//            avg, avg_valid, window_full, congested out)
// Optional feature macro: CONGESTION_FLAG_EN enables the hysteresis
// congestion flag; without it congested is tied low.
// ---------------------------------------------------------------------------
module road_sensor_avg
    import sensor_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SIZE      = SIZE_DEF,
    parameter int ROAD_W    = ROAD_W_DEF,
    parameter int ROAD_ID   = int'(SOUTH),
    parameter int INIT_VAL  = INIT_VAL_DEF,
    parameter int THRESH_HI = 60,
    parameter int THRESH_LO = 40
) (
    input  logic            clk,
    input  logic            reset,
    road_sensor_avg_if.slave bus
);

    localparam int                LEN       = windowLen(SIZE);
    localparam int                SUM_W     = DATA_W + SIZE;
    localparam int                FILL_W    = SIZE + 1;
    localparam logic [ROAD_W-1:0] ROAD_CODE = ROAD_W'(ROAD_ID);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(LEN);

    sel_e              r_sel;
    sel_e              w_sel_next;
    logic              w_granted;
    logic              w_capture;
    logic [SUM_W-1:0]  w_sum_next;
    logic [DATA_W-1:0] w_avg_next;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [FILL_W-1:0] w_fill_next;
    logic [DATA_W-1:0] r_avg;
    logic              r_avg_valid;
    logic              r_window_full;

    assign w_granted = (bus.next_road == ROAD_CODE);

    sensor_window_ram #(
        .DATA_W   (DATA_W),
        .SIZE     (SIZE),
        .INIT_VAL (INIT_VAL)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_capture),
        .i_wr_data  (bus.data_in),
        .o_sum_next (w_sum_next)
    );

    // Divide by the window length by dropping the low SIZE bits
    assign w_avg_next = w_sum_next[SUM_W-1:SIZE];

    // Sample counter saturates at a full window
    assign w_fill_next = (r_fill_cnt == FILL_MAX) ? r_fill_cnt : r_fill_cnt + FILL_W'(1);

    // Selection FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= SEL_IDLE;
        end else begin
            r_sel <= w_sel_next;
        end
    end

    // Selection FSM next state: leave GRANTED only when the grant moves on
    always_comb begin
        w_sel_next = r_sel;
        case (r_sel)
            SEL_IDLE:    if (w_granted)  w_sel_next = SEL_GRANTED;
            SEL_GRANTED: if (!w_granted) w_sel_next = SEL_IDLE;
            default:     w_sel_next = SEL_IDLE;
        endcase
    end

    // Selection FSM output: capture only on the first cycle of a grant
    always_comb begin
        w_capture = 1'b0;
        case (r_sel)
            SEL_IDLE: w_capture = w_granted;
            default:  w_capture = 1'b0;
        endcase
    end

    // Registered average, valid strobe, fill counter and full flag.
    // window_full stays high because the counter saturates at LEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_avg         <= DATA_W'(INIT_VAL);
            r_avg_valid   <= 1'b0;
            r_fill_cnt    <= '0;
            r_window_full <= 1'b0;
        end else begin
            r_avg_valid <= w_capture;
            if (w_capture) begin
                r_avg         <= w_avg_next;
                r_fill_cnt    <= w_fill_next;
                r_window_full <= (w_fill_next == FILL_MAX);
            end
        end
    end

`ifdef CONGESTION_FLAG_EN
    logic r_congested;

    // Hysteresis on the freshly computed average; between the two
    // thresholds the flag keeps its previous value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_congested <= 1'b0;
        end else if (w_capture) begin
            if (w_avg_next >= DATA_W'(THRESH_HI)) begin
                r_congested <= 1'b1;
            end else if (w_avg_next <= DATA_W'(THRESH_LO)) begin
                r_congested <= 1'b0;
            end
        end
    end

    assign bus.congested = r_congested;
`else
    assign bus.congested = 1'b0;
`endif

    assign bus.avg         = r_avg;
    assign bus.avg_valid   = r_avg_valid;
    assign bus.window_full = r_window_full;

endmodule : road_sensor_avg

// File: tb/tb_road_sensor_avg.sv
// ---------------------------------------------------------------------------
// tb_road_sensor_avg
// Directed bench for road_sensor_avg (ROAD_ID = SOUTH, default sizing).
// Honours CONGESTION_FLAG_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_road_sensor_avg;
    import sensor_pkg::*;

    logic clk;
    logic reset;

    int checkCount;
    int passCount;
    int failCount;
    int pulses;
    int expSum;
    int expAvg;
    logic expCong;

    road_sensor_avg_if #(.DATA_W(8), .ROAD_W(2)) bus ();

    road_sensor_avg #(
        .DATA_W    (8),
        .SIZE      (6),
        .ROAD_W    (2),
        .ROAD_ID   (2),
        .INIT_VAL  (20),
        .THRESH_HI (60),
        .THRESH_LO (40)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the controller-side inputs
    task automatic applyStimulus(input logic [1:0] road, input logic [7:0] data);
        bus.next_road = road;
        bus.data_in   = data;
    endtask

    // Advance past one rising edge and settle
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One comparison against a bench-computed value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Bench-side congestion expectation for a freshly updated average
    function automatic logic congModel(input logic prev, input int avgVal);
`ifdef CONGESTION_FLAG_EN
        if (avgVal >= 60) return 1'b1;
        if (avgVal <= 40) return 1'b0;
        return prev;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        expCong    = 1'b0;

        // Reset state and idle stability
        reset = 1'b1;
        applyStimulus(NORTH, 8'd0);
        stepCycle();
        stepCycle();
        reset = 1'b0;
        checkOutput("reset_avg", bus.avg, 20);
        checkOutput("reset_valid", bus.avg_valid, 0);
        checkOutput("reset_full", bus.window_full, 0);
        checkOutput("reset_cong", bus.congested, 0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("idle_avg", bus.avg, 20);
            checkOutput("idle_valid", bus.avg_valid, 0);
        end

        // Another road's grant must not capture
        applyStimulus(EAST, 8'd250);
        stepCycle();
        checkOutput("other_road_valid", bus.avg_valid, 0);
        checkOutput("other_road_avg", bus.avg, 20);

        // Single-cycle grant: 1280 + 84 - 20 = 1344 -> 21
        applyStimulus(SOUTH, 8'd84);
        stepCycle();
        checkOutput("first_avg", bus.avg, 21);
        checkOutput("first_valid", bus.avg_valid, 1);
        applyStimulus(NORTH, 8'd0);
        stepCycle();
        checkOutput("first_valid_drop", bus.avg_valid, 0);
        checkOutput("first_avg_hold", bus.avg, 21);

        // Long grant: one capture only; 1344 + 148 - 20 = 1472 -> 23
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(SOUTH, 8'(148 + i * 7));
            stepCycle();
            if (bus.avg_valid === 1'b1) pulses++;
            checkOutput("long_grant_avg", bus.avg, 23);
        end
        checkOutput("long_grant_pulses", pulses, 1);
        applyStimulus(NORTH, 8'd0);
        stepCycle();

        // Fresh window, then 64 grants of 100
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        expCong = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(SOUTH, 8'd100);
            stepCycle();
            expAvg  = (1280 + 80 * k) / 64;
            expCong = congModel(expCong, expAvg);
            checkOutput("fill_avg", bus.avg, expAvg);
            checkOutput("fill_cong", bus.congested, expCong);
            if (k == 63) checkOutput("full_before_64", bus.window_full, 0);
            if (k == 64) begin
                checkOutput("full_at_64", bus.window_full, 1);
                checkOutput("valid_at_64", bus.avg_valid, 1);
            end
            applyStimulus(NORTH, 8'd0);
            stepCycle();
        end
        checkOutput("avg_full_100", bus.avg, 100);

        // Wrap: slot 0 (100) replaced by 0 -> 6300 -> 98
        applyStimulus(SOUTH, 8'd0);
        stepCycle();
        expCong = congModel(expCong, 98);
        checkOutput("wrap_avg", bus.avg, 98);
        checkOutput("wrap_valid", bus.avg_valid, 1);
        checkOutput("wrap_full", bus.window_full, 1);
        applyStimulus(NORTH, 8'd0);
        stepCycle();
        checkOutput("wrap_avg_hold", bus.avg, 98);

        // Keep feeding zeros to walk the average down through THRESH_LO
        expSum = 6300;
        for (int j = 1; j <= 40; j++) begin
            applyStimulus(SOUTH, 8'd0);
            stepCycle();
            expSum  = expSum - 100;
            expAvg  = expSum / 64;
            expCong = congModel(expCong, expAvg);
            checkOutput("drain_avg", bus.avg, expAvg);
            checkOutput("drain_cong", bus.congested, expCong);
            checkOutput("drain_full", bus.window_full, 1);
            applyStimulus(NORTH, 8'd0);
            stepCycle();
        end

        // Reset while granted mid-window, then grant held across release
        reset = 1'b1;
        applyStimulus(SOUTH, 8'd200);
        stepCycle();
        checkOutput("midreset_avg", bus.avg, 20);
        checkOutput("midreset_full", bus.window_full, 0);
        checkOutput("midreset_valid", bus.avg_valid, 0);
        checkOutput("midreset_cong", bus.congested, 0);
        reset = 1'b0;
        stepCycle();
        // 1280 + 200 - 20 = 1460 -> 22
        checkOutput("post_reset_avg", bus.avg, 22);
        checkOutput("post_reset_valid", bus.avg_valid, 1);
        stepCycle();
        checkOutput("post_reset_single", bus.avg_valid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_road_sensor_avg
